// File: rtl/tlk2711_link_gen_pkg.sv
// Shared K-character word constants, generator FSM states and PRBS15 step function.
// The rx link path and rx checker use the same definitions.
package tlk2711_link_gen_pkg;

  localparam logic [15:0] K_IDLE_WORD = 16'hBC50;
  localparam logic [15:0] K_SOF_WORD  = 16'hFBFB;
  localparam logic [15:0] K_EOF_WORD  = 16'hFDFD;
  localparam logic [14:0] K_PRBS_SEED = 15'h7FFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_HDR,
    ST_PAY,
    ST_CSUM,
    ST_EOF,
    ST_GAP
  } state_t;

  // One bus word together with its K flags.
  typedef struct packed {
    logic        kmsb;
    logic        klsb;
    logic [15:0] d;
  } word_t;

  // x^15 + x^14 + 1, shifting towards the MSB.
  function automatic logic [14:0] prbs15_next(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

endpackage

// File: rtl/tlk2711_link_gen_if.sv
// Control/config inputs and TLK2711 rx word bus of the link-partner generator.
interface tlk2711_link_gen_if #(
  parameter int unsigned LEN_WIDTH = 16
);
  logic                 i_start;
  logic                 i_stop;
  logic                 i_link_en;
  logic [LEN_WIDTH-1:0] i_payload_len;
  logic [LEN_WIDTH-1:0] i_frame_num;
  logic [LEN_WIDTH-1:0] i_gap_len;
  logic                 i_pattern;
  logic                 i_inject_err;
  logic                 o_2711_rkmsb;
  logic                 o_2711_rklsb;
  logic [15:0]          o_2711_rxd;
  logic                 o_busy;
  logic                 o_done;
  logic [LEN_WIDTH-1:0] o_frame_cnt;

  modport master (
    output i_start, i_stop, i_link_en, i_payload_len, i_frame_num, i_gap_len,
           i_pattern, i_inject_err,
    input  o_2711_rkmsb, o_2711_rklsb, o_2711_rxd, o_busy, o_done, o_frame_cnt
  );

  modport slave (
    input  i_start, i_stop, i_link_en, i_payload_len, i_frame_num, i_gap_len,
           i_pattern, i_inject_err,
    output o_2711_rkmsb, o_2711_rklsb, o_2711_rxd, o_busy, o_done, o_frame_cnt
  );
endinterface

// File: rtl/tlk2711_prbs15.sv
// PRBS15 generator (x^15+x^14+1) with synchronous reseed; reseed has priority over enable.
module tlk2711_prbs15
  import tlk2711_link_gen_pkg::*;
#(
  parameter logic [14:0] SEED = K_PRBS_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        reseed_i,
  output logic [14:0] state_o
);

  logic [14:0] lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else if (reseed_i) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= prbs15_next(lfsr_q);
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/tlk2711_link_gen.sv
// Link-partner frame generator: drives framed SOF/HDR/PAY/CSUM/EOF traffic onto the
// TLK2711 rx word bus, one registered word per clock.
module tlk2711_link_gen
  import tlk2711_link_gen_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16,
  parameter logic [15:0] IDLE_WORD = K_IDLE_WORD,
  parameter logic [15:0] SOF_WORD  = K_SOF_WORD,
  parameter logic [15:0] EOF_WORD  = K_EOF_WORD,
  parameter logic [14:0] PRBS_SEED = K_PRBS_SEED
) (
  input logic               clk,
  input logic               rst,
  tlk2711_link_gen_if.slave bus
);

  state_t               state_q;
  word_t                out_q;
  logic                 busy_q, done_q, stop_q, pat_q, inj_q;
  logic [LEN_WIDTH-1:0] frame_cnt_q, len_q, num_q, gap_q, cnt_q;
  logic [15:0]          sum_q, idx_q;
  logic [14:0]          lfsr;
  logic [15:0]          pay_word_d;
  logic [LEN_WIDTH-1:0] frame_cnt_d;
  logic                 last_frame_d;

  // The LFSR runs one word ahead: reseeded outside a frame, stepped once in SOF so
  // that the first payload word loaded from HDR is already the advanced value.
  tlk2711_prbs15 #(.SEED(PRBS_SEED)) u_prbs (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q inside {ST_SOF, ST_HDR, ST_PAY}),
    .reseed_i (!(state_q inside {ST_SOF, ST_HDR, ST_PAY})),
    .state_o  (lfsr)
  );

  always_comb begin
    pay_word_d   = pat_q ? {1'b0, lfsr} : 16'(cnt_q);
    frame_cnt_d  = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + LEN_WIDTH'(1);
    last_frame_d = ((num_q != '0) && (frame_cnt_q == num_q)) || stop_q || bus.i_stop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_q       <= '{kmsb: 1'b1, klsb: 1'b0, d: IDLE_WORD};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_q      <= 1'b0;
      pat_q       <= 1'b0;
      inj_q       <= 1'b0;
      frame_cnt_q <= '0;
      len_q       <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (!bus.i_link_en) begin
        state_q <= ST_IDLE;
        out_q   <= '0;
        busy_q  <= 1'b0;
        stop_q  <= 1'b0;
      end else begin
        if (bus.i_stop && busy_q) stop_q <= 1'b1;
        unique case (state_q)
          ST_IDLE: begin
            out_q <= '{kmsb: 1'b1, klsb: 1'b0, d: IDLE_WORD};
            if (bus.i_start) begin
              len_q       <= bus.i_payload_len;
              num_q       <= bus.i_frame_num;
              gap_q       <= bus.i_gap_len;
              pat_q       <= bus.i_pattern;
              stop_q      <= bus.i_stop;
              frame_cnt_q <= '0;
              idx_q       <= '0;
              busy_q      <= 1'b1;
              state_q     <= ST_SOF;
              out_q       <= '{kmsb: 1'b1, klsb: 1'b1, d: SOF_WORD};
            end
          end
          ST_SOF: begin
            out_q   <= '{kmsb: 1'b0, klsb: 1'b0, d: idx_q};
            inj_q   <= bus.i_inject_err;
            sum_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_HDR;
          end
          ST_HDR, ST_PAY: begin
            if (cnt_q == len_q) begin
              out_q   <= '{kmsb: 1'b0, klsb: 1'b0, d: sum_q ^ {15'b0, inj_q}};
              state_q <= ST_CSUM;
            end else begin
              out_q   <= '{kmsb: 1'b0, klsb: 1'b0, d: pay_word_d};
              sum_q   <= sum_q + pay_word_d;
              cnt_q   <= cnt_q + LEN_WIDTH'(1);
              state_q <= ST_PAY;
            end
          end
          ST_CSUM: begin
            out_q       <= '{kmsb: 1'b1, klsb: 1'b1, d: EOF_WORD};
            frame_cnt_q <= frame_cnt_d;
            idx_q       <= idx_q + 16'd1;
            state_q     <= ST_EOF;
          end
          ST_EOF: begin
            if (last_frame_d) begin
              out_q   <= '{kmsb: 1'b1, klsb: 1'b0, d: IDLE_WORD};
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              stop_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else if (gap_q == '0) begin
              out_q   <= '{kmsb: 1'b1, klsb: 1'b1, d: SOF_WORD};
              state_q <= ST_SOF;
            end else begin
              out_q   <= '{kmsb: 1'b1, klsb: 1'b0, d: IDLE_WORD};
              cnt_q   <= LEN_WIDTH'(1);
              state_q <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (cnt_q == gap_q) begin
              out_q   <= '{kmsb: 1'b1, klsb: 1'b1, d: SOF_WORD};
              state_q <= ST_SOF;
            end else begin
              out_q <= '{kmsb: 1'b1, klsb: 1'b0, d: IDLE_WORD};
              cnt_q <= cnt_q + LEN_WIDTH'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_2711_rkmsb = out_q.kmsb;
  assign bus.o_2711_rklsb = out_q.klsb;
  assign bus.o_2711_rxd   = out_q.d;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_frame_cnt  = frame_cnt_q;

endmodule
